seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Parametrised, multiplexed seven-segment driver and successor to the fixed 8-digit scan display. It scans N_DIGITS hex digits with per-digit enable, decimal points, optional leading-zero blanking and PWM brightness. Display data is double-buffered so updates land only on frame boundaries, which prevents tearing. It sits between register/keyboard-data logic and the board's active-low SEG/AN/DP pins.

Parameters:
N_DIGITS, 8, number of digits scanned (1..8)
SCAN_DIV_W, 17, prescaler width; one digit slot = 2^SCAN_DIV_W clk cycles
BRIGHT_W, 4, brightness resolution in bits (BRIGHT_W <= SCAN_DIV_W)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
data  input  4*N_DIGITS  hex nibbles; digit i = data[4i+3:4i]
dp_in  input  N_DIGITS  decimal point per digit, 1 = lit
digit_en  input  N_DIGITS  1 = digit may be lit
load  input  1  capture data/dp_in/digit_en into pending buffer
blank_lz  input  1  1 = blank leading zeros
brightness  input  BRIGHT_W  on-time per slot
SEG  output  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low
AN  output  N_DIGITS  anodes, active-low
frame_done  output  1  one-cycle pulse at end of last digit slot

Behaviour:
- Reset (async, immediate):
  - Outputs: SEG=7'h7F, dp=1, AN=all ones, frame_done=0.
  - Internal state: prescaler div=0, digit index idx=0, pending/active buffers=0, pend_valid=0.
- Prescaler: div increments every clk and wraps. On the cycle div==all-ones, idx advances; idx wraps from N_DIGITS-1 to 0.
- Frame end: the cycle with div==all-ones and idx==N_DIGITS-1. frame_done registers high for exactly that edge's following cycle (period N_DIGITS*2^SCAN_DIV_W).
- Double buffer:
  - load=1 at a posedge writes the pending buffer and sets pend_valid. Repeated loads overwrite; the last one wins.
  - At the frame-end edge, if pend_valid (or load=1 on that same edge), the active buffer takes the pending contents and pend_valid clears.
  - If load coincides with frame end, the incoming input values go directly to active.
  - Display always reads the active buffer only.
- Decode (active-low, hex 0..F): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- Leading-zero blanking: when blank_lz=1, digit i>0 is blank if every active nibble j>=i is 0. Digit 0 is never blanked. A blank digit drives SEG=7F; its dp still follows dp_in and its anode still follows the rules below.
- Anode enable for slot idx requires all of:
  - active digit_en[idx]=1;
  - div!=0 (one-cycle ghosting guard at slot start);
  - PWM on, where PWM on = (brightness==all-ones) OR (div[SCAN_DIV_W-1 -: BRIGHT_W] < brightness).
  - brightness=0 means dark.
- AN drives the enabled digit low; all others stay high. SEG/dp reflect the active digit even when its anode is off.
- Timing: SEG, dp and AN are registered, with 1-cycle latency from div/idx. brightness and blank_lz are sampled live (no buffering).
- Width rules: div and idx are unsigned and wrap silently. idx width is clog2(N_DIGITS), minimum 1. When N_DIGITS=1, idx stays 0 and every slot is a frame end.
- rst asserted mid-frame: pending data and pend_valid are discarded, and the first post-reset frame displays zeros with all digits disabled.

Test Plan:
(All with N_DIGITS=4, SCAN_DIV_W=4, BRIGHT_W=2.)
1. Reset: assert rst mid-slot → same cycle AN=4'hF, SEG=7F, dp=1, frame_done=0. Release → first idx advance after 16 cycles; frame_done every 64 cycles.
2. Basic decode: load data=16'h12AF, digit_en=4'hF, dp_in=0, brightness=3 → after next frame_done:
   - slot0: SEG=0E, AN=1110;
   - slot1: SEG=08;
   - slot2: SEG=24;
   - slot3: SEG=79, AN=0111 (low for div 1..15).
3. Double buffering: load 16'h8888 mid-frame → remainder of current frame still shows 12AF; next frame shows 00. A load on the frame-end edge → the very next frame shows the new value.
4. Blanking: blank_lz=1, data=16'h0050 →
   - digits 3 and 2: SEG=7F;
   - digit 1: SEG=12;
   - digit 0: SEG=40.
   With data=0, only digit 0 shows 40.
5. Brightness: brightness=1 → AN low only for div 1..3 of each slot; brightness=0 → AN never low; brightness=2 → div 1..7.
6. Enable and dp: digit_en=4'b0101, dp_in=4'b0100 → AN[1] and AN[3] never low; dp=0 only during slot 2; dp=1 in every other slot.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed N-digit seven-segment scanner: double-buffered hex display with
// leading-zero blanking, per-digit enable, decimal points and PWM brightness.
module seven_seg_scanner #(
    parameter int unsigned N_DIGITS   = 8,
    parameter int unsigned SCAN_DIV_W = 17,
    parameter int unsigned BRIGHT_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   data,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [6:0]              SEG,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     AN,
    output logic                    frame_done
);

    localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned DATA_W = 4 * N_DIGITS;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [N_DIGITS-1:0] dp;
        logic [N_DIGITS-1:0] en;
    } disp_buf_t;

    logic [SCAN_DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    disp_buf_t             pend_q, pend_d;
    disp_buf_t             act_q, act_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    logic                  frame_done_q, frame_done_d;

    logic                  div_last, last_slot, frame_end;
    disp_buf_t             in_buf;
    logic [N_DIGITS-1:0]   blank_vec;
    logic                  zero_above;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_en, cur_blank;
    logic [BRIGHT_W-1:0]   pwm_slice;
    logic                  pwm_on, lit;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        hex_to_seg = 7'h7F;
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            4'hF: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Slot prescaler and digit index
    always_comb begin
        div_last  = &div_q;
        last_slot = (idx_q == IDX_W'(N_DIGITS - 1));
        frame_end = div_last && last_slot;
        div_d     = div_q + SCAN_DIV_W'(1);
        idx_d     = idx_q;
        if (div_last) begin
            idx_d = last_slot ? '0 : idx_q + IDX_W'(1);
        end
        frame_done_d = frame_end;
    end

    // Double buffer: pending collects loads, active swaps only at frame end
    always_comb begin
        in_buf.data  = data;
        in_buf.dp    = dp_in;
        in_buf.en    = digit_en;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        act_d        = act_q;
        if (load) begin
            pend_d       = in_buf;
            pend_valid_d = 1'b1;
        end
        if (frame_end) begin
            if (load) begin
                act_d = in_buf;
            end else if (pend_valid_q) begin
                act_d = pend_q;
            end
            pend_valid_d = 1'b0;
        end
    end

    // Digit selection, leading-zero detection and segment/anode drive
    always_comb begin
        zero_above = 1'b1;
        blank_vec  = '0;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            zero_above   = zero_above && (act_q.data[4*i +: 4] == 4'h0);
            blank_vec[i] = zero_above && (i != 0);
        end

        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = act_q.data[4*i +: 4];
                cur_dp    = act_q.dp[i];
                cur_en    = act_q.en[i];
                cur_blank = blank_lz && blank_vec[i];
            end
        end

        // div==0 keeps the anode dark for one cycle to avoid ghosting on slot change
        pwm_slice = div_q[SCAN_DIV_W-1 -: BRIGHT_W];
        pwm_on    = (&brightness) || (pwm_slice < brightness);
        lit       = cur_en && (div_q != '0) && pwm_on;

        seg_d = cur_blank ? 7'h7F : hex_to_seg(cur_nib);
        dp_d  = ~cur_dp;
        an_d  = '1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (lit && (idx_q == IDX_W'(i))) begin
                an_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= '0;
            pend_q       <= '0;
            act_q        <= '0;
            pend_valid_q <= 1'b0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            act_q        <= act_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SEG        = seg_q;
    assign dp         = dp_q;
    assign AN         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (4 digits, 16-cycle slots, 2-bit brightness):
// stimulus queues per-frame expectations, a monitor checks each captured frame.
module tb_seven_seg_scanner;

    localparam int NUM_WIN = 10;

    typedef struct packed {
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
        logic [3:0][3:0] an_hi;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic        load;
    logic        blank_lz;
    logic [1:0]  brightness;
    logic [6:0]  SEG;
    logic        dp;
    logic [3:0]  AN;
    logic        frame_done;

    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    seven_seg_scanner #(
        .N_DIGITS   (4),
        .SCAN_DIV_W (4),
        .BRIGHT_W   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .load       (load),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .SEG        (SEG),
        .dp         (dp),
        .AN         (AN),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [3:0] an_exp(input int s, input int d, input logic [3:0] hi);
        an_exp = 4'hF;
        if (d >= 1 && d <= int'(hi)) an_exp[s] = 1'b0;
    endfunction

    // One frame of stimulus; expectation describes what this frame must display
    task automatic run_window(input logic [1:0] b, input logic blz,
                              input logic mid, input logic [15:0] mdata,
                              input logic endl, input logic [15:0] edata,
                              input logic [3:0] en, input logic [3:0] dpi,
                              input logic [27:0] eseg, input logic [3:0] edp,
                              input logic [15:0] ean);
        exp_t e;
        brightness = b;
        blank_lz   = blz;
        load       = 1'b0;
        e.seg      = eseg;
        e.dp       = edp;
        e.an_hi    = ean;
        exp_q.push_back(e);
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 20 && mid) begin
                data = mdata; digit_en = en; dp_in = dpi; load = 1'b1;
            end else if (k == 21) begin
                load = 1'b0;
            end else if (k == 63 && endl) begin
                data = edata; digit_en = en; dp_in = dpi; load = 1'b1;
            end
        end
    endtask

    task automatic run_stimulus();
        run_window(2'd3, 1'b0, 1'b1, 16'h12AF, 1'b0, 16'h0000, 4'hF, 4'h0,
                   {7'h40, 7'h40, 7'h40, 7'h40}, 4'hF, 16'h0000);
        run_window(2'd3, 1'b0, 1'b1, 16'h8888, 1'b0, 16'h0000, 4'hF, 4'h0,
                   {7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 16'hFFFF);
        run_window(2'd3, 1'b0, 1'b1, 16'h7777, 1'b1, 16'h0050, 4'hF, 4'h0,
                   {7'h00, 7'h00, 7'h00, 7'h00}, 4'hF, 16'hFFFF);
        run_window(2'd3, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 4'hF, 4'h0,
                   {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF, 16'hFFFF);
        run_window(2'd3, 1'b1, 1'b1, 16'h9C3D, 1'b0, 16'h0000, 4'hF, 4'h0,
                   {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF, 16'hFFFF);
        run_window(2'd1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'hF, 4'h0,
                   {7'h10, 7'h46, 7'h30, 7'h21}, 4'hF, 16'h3333);
        run_window(2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'hF, 4'h0,
                   {7'h10, 7'h46, 7'h30, 7'h21}, 4'hF, 16'h0000);
        run_window(2'd2, 1'b0, 1'b1, 16'h6E4B, 1'b0, 16'h0000, 4'b0101, 4'b0100,
                   {7'h10, 7'h46, 7'h30, 7'h21}, 4'hF, 16'h7777);
        run_window(2'd3, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1000, 4'hF, 4'b1010,
                   {7'h02, 7'h06, 7'h19, 7'h03}, 4'b1011, 16'h0F0F);
        run_window(2'd3, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'hF, 4'h0,
                   {7'h79, 7'h40, 7'h40, 7'h40}, 4'b0101, 16'hFFFF);
        load = 1'b0;
    endtask

    // Captures 64 samples per frame and compares them against the queued expectation
    task automatic run_monitor();
        logic [6:0] seg_s [64];
        logic [3:0] an_s  [64];
        logic       dp_s  [64];
        logic       fd_s  [64];
        exp_t       e;
        logic       fd_early;
        for (int w = 0; w < NUM_WIN; w++) begin
            for (int j = 0; j < 64; j++) begin
                @(negedge clk);
                seg_s[j] = SEG;
                an_s[j]  = AN;
                dp_s[j]  = dp;
                fd_s[j]  = frame_done;
            end
            fd_early = 1'b0;
            for (int j = 0; j < 63; j++) fd_early = fd_early | fd_s[j];
            check($sformatf("w%0d frame_done {last,early}", w),
                  32'({fd_s[63], fd_early}), 32'(2'b10));
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL w%0d expectation queue: got empty, expected an entry", w);
            end else begin
                e = exp_q.pop_front();
                for (int s = 0; s < 4; s++) begin
                    logic [6:0] seg_a;
                    logic       dp_a;
                    logic [3:0] an_a, an_e;
                    logic       seg_bad, dp_bad, an_bad;
                    int         seg_dv, dp_dv, an_dv;
                    seg_a = seg_s[s*16]; dp_a = dp_s[s*16];
                    an_a  = an_s[s*16+1]; an_e = an_exp(s, 1, e.an_hi[s]);
                    seg_bad = 1'b0; dp_bad = 1'b0; an_bad = 1'b0;
                    seg_dv = 0; dp_dv = 0; an_dv = 1;
                    for (int d = 0; d < 16; d++) begin
                        int j;
                        j = s*16 + d;
                        if (!seg_bad && seg_s[j] != e.seg[s]) begin
                            seg_bad = 1'b1; seg_a = seg_s[j]; seg_dv = d;
                        end
                        if (!dp_bad && dp_s[j] != e.dp[s]) begin
                            dp_bad = 1'b1; dp_a = dp_s[j]; dp_dv = d;
                        end
                        if (!an_bad && an_s[j] != an_exp(s, d, e.an_hi[s])) begin
                            an_bad = 1'b1; an_a = an_s[j]; an_e = an_exp(s, d, e.an_hi[s]); an_dv = d;
                        end
                    end
                    check($sformatf("w%0d slot%0d SEG div%0d", w, s, seg_dv), 32'(seg_a), 32'(e.seg[s]));
                    check($sformatf("w%0d slot%0d dp div%0d", w, s, dp_dv), 32'(dp_a), 32'(e.dp[s]));
                    check($sformatf("w%0d slot%0d AN div%0d", w, s, an_dv), 32'(an_a), 32'(an_e));
                end
            end
        end
    endtask

    initial begin
        int   n;
        int   bad;
        logic found;
        rst = 1'b1; data = '0; dp_in = '0; digit_en = '0;
        load = 1'b0; blank_lz = 1'b0; brightness = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // First frame after release: load 12AF into pending mid-frame
        n = 0; found = 1'b0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 30) begin
                data = 16'h12AF; digit_en = 4'hF; dp_in = 4'h0; brightness = 2'd3; load = 1'b1;
            end else if (n == 31) begin
                load = 1'b0;
            end
            if (frame_done) found = 1'b1;
        end
        check("first frame_done cycle", 32'(n), 32'd64);

        // Second frame shows 12AF; queue 8888 in pending, then reset mid-slot
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 20) begin
                data = 16'h8888; load = 1'b1;
            end else if (k == 21) begin
                load = 1'b0;
            end
            if (k == 40) begin
                check("pre-reset AN slot2", 32'(AN), 32'(4'hB));
                check("pre-reset SEG slot2", 32'(SEG), 32'(7'h24));
            end
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("reset AN", 32'(AN), 32'(4'hF));
        check("reset SEG", 32'(SEG), 32'(7'h7F));
        check("reset dp", 32'(dp), 32'(1'b1));
        check("reset frame_done", 32'(frame_done), 32'(1'b0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        n = 0; found = 1'b0; bad = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (frame_done) found = 1'b1;
            else if (AN != 4'hF || SEG != 7'h40 || dp != 1'b1) bad++;
        end
        check("post-reset frame_done cycle", 32'(n), 32'd64);
        check("post-reset frame dark samples", 32'(bad), 32'd0);

        fork
            run_stimulus();
            run_monitor();
        join

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
